i2c_cmd_arbiter: RTL and testbench

//  Shares one I2C_Controller between two command sources: the power-up register config sequencer and a runtime writer (e.g. volume/format updates).

---
 rtl/i2c_cmd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C_Controller between two 24-bit command sources: round-robin grant,
// GO/END handshake, NACK retry, END timeout and per-command DONE/ERR reporting.
module i2c_cmd_arbiter #(
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iREQ0_VALID,
  input  logic [23:0] iREQ0_DATA,
  output logic        oREQ0_READY,
  output logic        oREQ0_DONE,
  input  logic        iREQ1_VALID,
  input  logic [23:0] iREQ1_DATA,
  output logic        oREQ1_READY,
  output logic        oREQ1_DONE,
  output logic        oERR,
  output logic [23:0] oI2C_DATA,
  output logic        oI2C_GO,
  input  logic        iI2C_END,
  input  logic        iI2C_ACK,
  output logic        oBUSY
);

  localparam int unsigned RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TW   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned GCYC = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int unsigned GW   = $clog2(GCYC + 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT, CHECK, GAP, DONE_OK, DONE_ERR
  } state_t;

  state_t        state;
  state_t        gapNext;
  logic          lastGrant;
  logic [RW-1:0] retryCnt;
  logic [TW-1:0] tmr;
  logic [GW-1:0] gapCnt;
  logic          anyValid;
  logic          pick1;

  always_comb begin
    anyValid = iREQ0_VALID || iREQ1_VALID;
    pick1    = iREQ1_VALID && (!iREQ0_VALID || !lastGrant);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      gapNext     <= IDLE;
      lastGrant   <= 1'b1;
      retryCnt    <= '0;
      tmr         <= '0;
      gapCnt      <= '0;
      oREQ0_READY <= 1'b0;
      oREQ1_READY <= 1'b0;
      oREQ0_DONE  <= 1'b0;
      oREQ1_DONE  <= 1'b0;
      oERR        <= 1'b0;
      oI2C_DATA   <= '0;
      oI2C_GO     <= 1'b0;
      oBUSY       <= 1'b0;
    end else begin
      oREQ0_READY <= 1'b0;
      oREQ1_READY <= 1'b0;
      oREQ0_DONE  <= 1'b0;
      oREQ1_DONE  <= 1'b0;
      case (state)
        IDLE: begin
          if (anyValid) begin
            if (pick1) begin
              oREQ1_READY <= 1'b1;
              oI2C_DATA   <= iREQ1_DATA;
              lastGrant   <= 1'b1;
            end else begin
              oREQ0_READY <= 1'b1;
              oI2C_DATA   <= iREQ0_DATA;
              lastGrant   <= 1'b0;
            end
            tmr   <= '0;
            oBUSY <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (tmr == TW'(TIMEOUT_CYC)) begin
            oI2C_GO    <= 1'b0;
            oREQ0_DONE <= !lastGrant;
            oREQ1_DONE <= lastGrant;
            oERR       <= 1'b1;
            state      <= DONE_ERR;
          end else begin
            oI2C_GO <= 1'b1;
            // END is only trusted once GO has actually been presented to the controller
            if (oI2C_GO && !iI2C_END) begin
              tmr   <= '0;
              state <= WAIT;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
        end
        WAIT: begin
          if (tmr == TW'(TIMEOUT_CYC)) begin
            oI2C_GO    <= 1'b0;
            oREQ0_DONE <= !lastGrant;
            oREQ1_DONE <= lastGrant;
            oERR       <= 1'b1;
            state      <= DONE_ERR;
          end else if (iI2C_END) begin
            oI2C_GO <= 1'b0;
            state   <= CHECK;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        CHECK: begin
          oI2C_GO <= 1'b0;
          if (!iI2C_ACK) begin
            oREQ0_DONE <= !lastGrant;
            oREQ1_DONE <= lastGrant;
            oERR       <= 1'b0;
            state      <= DONE_OK;
          end else if (retryCnt < RW'(MAX_RETRY)) begin
            retryCnt <= retryCnt + RW'(1);
            gapCnt   <= '0;
            gapNext  <= START;
            state    <= GAP;
          end else begin
            oREQ0_DONE <= !lastGrant;
            oREQ1_DONE <= lastGrant;
            oERR       <= 1'b1;
            state      <= DONE_ERR;
          end
        end
        GAP: begin
          if (gapCnt == GW'(GCYC - 1)) begin
            state <= gapNext;
            tmr   <= '0;
            if (gapNext == IDLE) oBUSY <= 1'b0;
          end else begin
            gapCnt <= gapCnt + GW'(1);
          end
        end
        DONE_OK, DONE_ERR: begin
          oERR     <= 1'b0;
          retryCnt <= '0;
          gapCnt   <= '0;
          gapNext  <= IDLE;
          state    <= GAP;
        end
        default: begin
          oI2C_GO <= 1'b0;
          oBUSY   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: behavioural I2C_Controller model, vector table of
// single commands, plus hand sequences for arbitration and mid-transfer reset.
module tb_i2c_cmd_arbiter;

  localparam int MR  = 3;
  localparam int TO  = 20;
  localparam int GAP = 2;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iREQ0_VALID, iREQ1_VALID;
  logic [23:0] iREQ0_DATA, iREQ1_DATA;
  logic        oREQ0_READY, oREQ0_DONE, oREQ1_READY, oREQ1_DONE;
  logic        oERR, oI2C_GO, oBUSY;
  logic [23:0] oI2C_DATA;
  logic        iI2C_END, iI2C_ACK;

  i2c_cmd_arbiter #(.MAX_RETRY(MR), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iREQ0_VALID(iREQ0_VALID), .iREQ0_DATA(iREQ0_DATA),
    .oREQ0_READY(oREQ0_READY), .oREQ0_DONE(oREQ0_DONE),
    .iREQ1_VALID(iREQ1_VALID), .iREQ1_DATA(iREQ1_DATA),
    .oREQ1_READY(oREQ1_READY), .oREQ1_DONE(oREQ1_DONE),
    .oERR(oERR), .oI2C_DATA(oI2C_DATA), .oI2C_GO(oI2C_GO),
    .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // controller model: END low for 5 cycles after each GO rise; NACKs the first nackFirst attempts
  int   nackBase  = 0;
  int   nackFirst = 0;
  logic stuck     = 1'b0;
  int   mBusy     = 0;
  int   mPulses   = 0;
  logic mGoPrev   = 1'b0;
  logic mAck      = 1'b0;

  always @(posedge iCLK) begin
    mGoPrev <= oI2C_GO;
    if (oI2C_GO && !mGoPrev) begin
      mPulses <= mPulses + 1;
      mAck    <= ((mPulses - nackBase + 1) <= nackFirst);
      if (!stuck) mBusy <= 5;
    end else if (mBusy != 0) begin
      mBusy <= mBusy - 1;
    end
  end
  assign iI2C_END = (mBusy == 0);
  assign iI2C_ACK = mAck;

  // output monitor, sampled just after each rising edge
  int   r0Cnt = 0, r1Cnt = 0, d0Cnt = 0, d1Cnt = 0, goPulses = 0;
  int   lowRun = 0, highRun = 0, lastHigh = 0, minLow = 1000;
  logic firstPulse = 1'b0, goPrevM = 1'b0;

  always @(posedge iCLK) begin
    #1;
    if (oREQ0_READY) r0Cnt++;
    if (oREQ1_READY) r1Cnt++;
    if (oREQ0_DONE) d0Cnt++;
    if (oREQ1_DONE) d1Cnt++;
    if (oREQ0_READY || oREQ1_READY) begin
      firstPulse = 1'b1;
      minLow     = 1000;
    end
    if (oI2C_GO) begin
      if (!goPrevM) begin
        goPulses++;
        if (!firstPulse && lowRun < minLow) minLow = lowRun;
        firstPulse = 1'b0;
        highRun    = 0;
      end
      highRun++;
    end else begin
      if (goPrevM) begin
        lastHigh = highRun;
        lowRun   = 0;
      end
      lowRun++;
    end
    goPrevM = oI2C_GO;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkRange(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic waitReady(input string name, output logic port, output int cyc);
    bit ok = 0;
    port = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge iCLK);
      cyc++;
      if (oREQ0_READY || oREQ1_READY) begin
        ok   = 1;
        port = oREQ1_READY;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s ready timeout: got none expected READY within 60 cycles", name);
    end
  endtask

  task automatic waitDone(input string name, output logic port, output logic err, output logic [23:0] data);
    bit ok = 0;
    port = 1'b0;
    err  = 1'b0;
    data = '0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge iCLK);
      if (oREQ0_DONE || oREQ1_DONE) begin
        ok   = 1;
        port = oREQ1_DONE;
        err  = oERR;
        data = oI2C_DATA;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s done timeout: got none expected DONE within 400 cycles", name);
    end
  endtask

  task automatic waitIdle(input string name);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge iCLK);
      if (!oBUSY) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s idle timeout: got BUSY=1 expected BUSY=0 within 30 cycles", name);
    end
  endtask

  typedef struct {
    logic        port;
    logic [23:0] data;
    int          nackN;
    logic        stk;
    logic        expErr;
    int          expPulses;
  } vec_t;

  vec_t vecs[7];

  task automatic runVec(input int idx, input vec_t v);
    logic port, dport, derr, goAtReady, goNext;
    logic [23:0] ddata;
    int cyc, rs, ds, ps;
    string tag;
    tag       = $sformatf("vec%0d", idx);
    nackBase  = mPulses;
    nackFirst = v.nackN;
    stuck     = v.stk;
    rs = r0Cnt + r1Cnt;
    ds = d0Cnt + d1Cnt;
    ps = goPulses;
    @(negedge iCLK);
    if (v.port) begin iREQ1_VALID = 1'b1; iREQ1_DATA = v.data; end
    else        begin iREQ0_VALID = 1'b1; iREQ0_DATA = v.data; end
    waitReady(tag, port, cyc);
    goAtReady   = oI2C_GO;
    iREQ0_VALID = 1'b0;
    iREQ1_VALID = 1'b0;
    chk({tag, " grant port"}, {31'd0, port}, {31'd0, v.port});
    @(negedge iCLK);
    goNext = oI2C_GO;
    chk({tag, " GO after READY"}, {30'd0, goAtReady, goNext}, 32'd1);
    waitDone(tag, dport, derr, ddata);
    chk({tag, " done port"}, {31'd0, dport}, {31'd0, v.port});
    chk({tag, " err"}, {31'd0, derr}, {31'd0, v.expErr});
    chk({tag, " data"}, {8'd0, ddata}, {8'd0, v.data});
    waitIdle(tag);
    chk({tag, " go pulses"}, goPulses - ps, v.expPulses);
    chk({tag, " ready count"}, r0Cnt + r1Cnt - rs, 1);
    chk({tag, " done count"}, d0Cnt + d1Cnt - ds, 1);
    if (v.expPulses > 1) chkRange({tag, " retry low gap"}, minLow, GAP, 1000);
    if (v.stk) chkRange({tag, " timeout GO width"}, lastHigh, TO - 1, TO + 1);
    stuck = 1'b0;
  endtask

  initial begin
    logic port, dport, derr;
    logic [23:0] ddata;
    int cyc, ds;

    vecs[0] = '{1'b0, 24'h341A01, 0, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b1, 24'h1234AB, 2, 1'b0, 1'b0, 3};
    vecs[2] = '{1'b0, 24'h3C0F55, 9, 1'b0, 1'b1, 4};
    vecs[3] = '{1'b1, 24'h341E00, 0, 1'b0, 1'b0, 1};
    vecs[4] = '{1'b0, 24'h340C7E, 0, 1'b1, 1'b1, 1};
    vecs[5] = '{1'b1, 24'h340A11, 1, 1'b0, 1'b0, 2};
    vecs[6] = '{1'b0, 24'hFFFFFF, 3, 1'b0, 1'b0, 4};

    iRST_N      = 1'b0;
    iREQ0_VALID = 1'b0;
    iREQ1_VALID = 1'b0;
    iREQ0_DATA  = '0;
    iREQ1_DATA  = '0;
    repeat (3) @(negedge iCLK);
    chk("reset GO", {31'd0, oI2C_GO}, 32'd0);
    chk("reset BUSY", {31'd0, oBUSY}, 32'd0);
    chk("reset DATA", {8'd0, oI2C_DATA}, 32'd0);
    chk("reset strobes", {27'd0, oREQ0_READY, oREQ1_READY, oREQ0_DONE, oREQ1_DONE, oERR}, 32'd0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    // simultaneous requests after reset: req0, then req1, then req0 again
    nackBase   = mPulses;
    nackFirst  = 0;
    iREQ0_DATA = 24'h34AA01;
    iREQ1_DATA = 24'h34BB02;
    iREQ0_VALID = 1'b1;
    iREQ1_VALID = 1'b1;
    waitReady("arb1", port, cyc);
    chk("arb1 ready pair", {30'd0, oREQ1_READY, oREQ0_READY}, 32'd1);
    iREQ0_VALID = 1'b0;
    waitDone("arb1", dport, derr, ddata);
    chk("arb1 done port", {31'd0, dport}, 32'd0);
    waitReady("arb2", port, cyc);
    chk("arb2 grant port", {31'd0, port}, 32'd1);
    chkRange("arb2 latency after DONE", cyc, 1 + GAP, 60);
    chk("arb2 data", {8'd0, oI2C_DATA}, 32'h0034BB02);
    iREQ1_VALID = 1'b0;
    waitDone("arb2", dport, derr, ddata);
    chk("arb2 done port", {31'd0, dport}, 32'd1);
    waitIdle("arb2");
    @(negedge iCLK);
    iREQ0_VALID = 1'b1;
    iREQ1_VALID = 1'b1;
    waitReady("arb3", port, cyc);
    chk("arb3 grant port", {31'd0, port}, 32'd0);
    iREQ0_VALID = 1'b0;
    iREQ1_VALID = 1'b0;
    waitDone("arb3", dport, derr, ddata);
    chk("arb3 done port", {31'd0, dport}, 32'd0);
    waitIdle("arb3");

    for (int i = 0; i < 7; i++) runVec(i, vecs[i]);

    // reset in WAIT: GO/BUSY fall asynchronously, no DONE, req0 wins afterwards
    nackBase   = mPulses;
    nackFirst  = 0;
    @(negedge iCLK);
    iREQ0_DATA  = 24'h34CC55;
    iREQ0_VALID = 1'b1;
    waitReady("rst", port, cyc);
    iREQ0_VALID = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge iCLK);
        if (!iI2C_END) seen = 1;
      end
      chk("rst controller started", {31'd0, seen}, 32'd1);
    end
    @(negedge iCLK);
    chk("rst pre GO/BUSY", {30'd0, oI2C_GO, oBUSY}, 32'd3);
    ds = d0Cnt + d1Cnt;
    #2;
    iRST_N = 1'b0;
    #1;
    chk("rst async GO", {31'd0, oI2C_GO}, 32'd0);
    chk("rst async BUSY", {31'd0, oBUSY}, 32'd0);
    iREQ0_DATA  = 24'h341A02;
    iREQ1_DATA  = 24'h341A03;
    iREQ0_VALID = 1'b1;
    iREQ1_VALID = 1'b1;
    repeat (8) @(negedge iCLK);
    iRST_N = 1'b1;
    waitReady("rst regrant", port, cyc);
    chk("rst regrant port", {31'd0, port}, 32'd0);
    chk("rst no DONE", d0Cnt + d1Cnt - ds, 0);
    iREQ0_VALID = 1'b0;
    iREQ1_VALID = 1'b0;
    waitDone("rst regrant", dport, derr, ddata);
    chk("rst regrant done", {30'd0, dport, derr}, 32'd0);
    chk("rst regrant data", {8'd0, ddata}, 32'h00341A02);
    waitIdle("rst regrant");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
